unidade_busca: RTL and testbench
================================

# unidade_busca

Instruction-fetch stage of the pipelined datapath. Owns the program counter and drives `endereco_PC` into the combinational instruction memory. Captures the returned instruction, together with PC+4, into the IF/ID pipeline register. Handles sequential advance, branch/jump/jr redirects, stalls and flushes.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_0000, PC value loaded on reset.
- `NOP`, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- `clock`  in  1  Single clock; all state updates on the rising edge.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `stall`  in  1  Hazard stall from ID; holds PC and IF/ID.
- `flush`  in  1  Forces a bubble into IF/ID on the next edge.
- `branch_taken`  in  1  Branch resolved taken in ID.
- `branch_offset`  in  32  Sign-extended branch immediate, in words.
- `jump`  in  1  j/jal in ID.
- `jump_target`  in  26  Instruction index field.
- `jr`  in  1  jr in ID.
- `jr_endereco`  in  32  Register value for jr.
- `instrucao_in`  in  32  Instruction word returned by instruction memory for `endereco_PC`.
- `endereco_PC`  out  32  Current PC to instruction memory.
- `instrucao_ifid`  out  32  IF/ID instruction.
- `pc_mais4_ifid`  out  32  IF/ID PC+4.
- `valido_ifid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `erro_alinhamento`  out  1  Sticky misaligned-jr flag (see Configuration).

## Operation
- The next PC is selected in this priority order: `jr` > `jump` > `branch_taken` > sequential.
  - jr: `jr_endereco`.
  - jump: {`pc_mais4_ifid`[31:28], `jump_target`, 2'b00}.
  - branch: `pc_mais4_ifid` + (`branch_offset` << 2), modulo 2^32.
  - sequential: `endereco_PC` + 4, wrapping at 2^32.
- Redirect means any of `jr`/`jump`/`branch_taken` is high and `stall` is low. On a redirect:
  - PC loads the target.
  - IF/ID loads a bubble: `NOP`, valido 0. The wrong-path fetch is squashed; there are no delay slots.
- `stall` high: PC, IF/ID and all outputs hold. Redirect and `flush` are ignored in that cycle; ID re-presents them after the stall.
- `flush` high with `stall` low and no redirect: PC advances sequentially; IF/ID loads a bubble.
- Normal cycle:
  - IF/ID loads `instrucao_in`, `endereco_PC`+4 and valido 1.
  - PC loads `endereco_PC`+4.

## Timing
- Reset (async assert, takes effect immediately):
  - `endereco_PC` = `PC_RESET`, `instrucao_ifid` = `NOP`, `pc_mais4_ifid` = 0, `valido_ifid` = 0, `erro_alinhamento` = 0.
- Instruction memory is combinational: `instrucao_in` is valid in the same cycle as `endereco_PC`.
- Fetch-to-IF/ID latency: 1 edge.
- Redirect penalty: 1 bubble. The target instruction appears in IF/ID 2 edges after the redirect cycle.
- First edge after `reset_n` deasserts: IF/ID = instruction at `PC_RESET`, valido 1, PC = `PC_RESET`+4.
- Reset asserted mid-stall or mid-redirect: reset wins; no pending redirect is retained.
- Outputs are registers only; there is no combinational path from inputs to outputs.

## Configuration
- Macro `FETCH_ALINHAMENTO_CHECK_EN`.
- Defined:
  - A jr redirect with `jr_endereco`[1:0] != 0 does not load the PC.
  - It sets `erro_alinhamento` (sticky until reset).
  - From then on, PC freezes and IF/ID loads bubbles every non-stall cycle.
- Undefined:
  - `erro_alinhamento` is tied 0.
  - The jr target low two bits are forced to 2'b00.

## Structure
- The shared package holds:
  - the `NOP` constant;
  - next-PC select encoding `SEL_SEQ`, `SEL_BRANCH`, `SEL_JUMP`, `SEL_JR`;
  - `PC_INCREMENTO` = 4.
- One sub-module, `calc_prox_pc`: combinational target computation and priority select, returning the next PC plus a redirect flag.
- PC, IF/ID and error registers live in `unidade_busca`.

## Test plan
- Reset then free run, `PC_RESET`=0, memory words 0..3 = A,B,C,D → `endereco_PC` 0,4,8,12 on successive edges; IF/ID shows A (pc_mais4 4), then B (8), then C (12); valido 1.
- `branch_taken`=1, `branch_offset`=-2, `pc_mais4_ifid`=0x10 → next PC 0x08; IF/ID bubble (valido 0) for one cycle; then the instruction at 0x08 appears with pc_mais4 0x0C.
- `jump`=1 with `jr`=1 and `branch_taken`=1 in the same cycle, `jr_endereco`=0x40 → PC=0x40 (jr wins); exactly one bubble.
- `stall` held 3 cycles with `branch_taken`=1 → PC and IF/ID unchanged for all 3 cycles; the redirect applies only on the first non-stall edge.
- `flush` pulse at PC=0x20 → PC=0x24; IF/ID = `NOP`, valido 0; normal capture resumes next edge.
- With the macro defined, `jr`=1 and `jr_endereco`=0x42 → `erro_alinhamento`=1; PC holds; bubbles every cycle until `reset_n` pulses low, after which all outputs return to reset values.

Source files
------------

// File: rtl/unidade_busca_pkg.sv
// unidade_busca_pkg: shared constants and types for the instruction-fetch stage.
// Holds the bubble word, the PC increment, the next-PC select encoding and the
// IF/ID register layout.
package unidade_busca_pkg;

   localparam logic [31:0] NOP           = 32'h0000_0000;
   localparam logic [31:0] PC_INCREMENTO = 32'd4;

   // Next-PC source, listed from lowest to highest priority
   typedef enum logic [1:0] {
      SEL_SEQ    = 2'd0,
      SEL_BRANCH = 2'd1,
      SEL_JUMP   = 2'd2,
      SEL_JR     = 2'd3
   } sel_prox_t;

   // IF/ID pipeline register contents
   typedef struct packed {
      logic [31:0] instrucao;
      logic [31:0] pc_mais4;
      logic        valido;
   } ifid_t;

   // Branch target: word offset scaled to bytes, modulo 2^32
   function automatic logic [31:0] alvo_desvio(input logic [31:0] pc_mais4,
                                               input logic [31:0] offset);
      return pc_mais4 + {offset[29:0], 2'b00};
   endfunction

endpackage

// File: rtl/unidade_busca_if.sv
// unidade_busca_if: groups the fetch-stage control inputs from ID, the
// instruction-memory port and the IF/ID outputs. The slave modport is the
// fetch unit; the master modport is the surrounding datapath.
interface unidade_busca_if;

   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic        jump;
   logic [25:0] jump_target;
   logic        jr;
   logic [31:0] jr_endereco;
   logic [31:0] instrucao_in;
   logic [31:0] endereco_PC;
   logic [31:0] instrucao_ifid;
   logic [31:0] pc_mais4_ifid;
   logic        valido_ifid;
   logic        erro_alinhamento;

   modport master (
      output stall, flush, branch_taken, branch_offset, jump, jump_target,
             jr, jr_endereco, instrucao_in,
      input  endereco_PC, instrucao_ifid, pc_mais4_ifid, valido_ifid,
             erro_alinhamento
   );

   modport slave (
      input  stall, flush, branch_taken, branch_offset, jump, jump_target,
             jr, jr_endereco, instrucao_in,
      output endereco_PC, instrucao_ifid, pc_mais4_ifid, valido_ifid,
             erro_alinhamento
   );

endinterface

// File: rtl/unidade_busca_calc_prox_pc.sv
// calc_prox_pc: combinational redirect-target computation and next-PC select.
// Priority jr > jump > branch > sequential. With FETCH_ALINHAMENTO_CHECK_EN
// undefined the jr target is word-aligned here; with it defined the raw value
// is passed through and the caller decides what a misaligned jr does.
module calc_prox_pc
   import unidade_busca_pkg::*;
(
   input  logic [31:0] endereco_pc,
   input  logic [31:0] pc_mais4_ifid,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_endereco,
   output logic [31:0] prox_pc,
   output logic        redirect
);

   sel_prox_t   sel;
   logic [31:0] alvo_jr;

`ifdef FETCH_ALINHAMENTO_CHECK_EN
   assign alvo_jr = jr_endereco;
`else
   assign alvo_jr = jr_endereco & ~32'h3;
`endif

   // Priority select of the next-PC source
   always_comb begin
      sel = SEL_SEQ;
      if (jr)                sel = SEL_JR;
      else if (jump)         sel = SEL_JUMP;
      else if (branch_taken) sel = SEL_BRANCH;
   end

   // Target mux; sequential path wraps naturally at 2^32
   always_comb begin
      prox_pc = endereco_pc + PC_INCREMENTO;
      unique case (sel)
         SEL_JR:     prox_pc = alvo_jr;
         SEL_JUMP:   prox_pc = {pc_mais4_ifid[31:28], jump_target, 2'b00};
         SEL_BRANCH: prox_pc = alvo_desvio(pc_mais4_ifid, branch_offset);
         default:    prox_pc = endereco_pc + PC_INCREMENTO;
      endcase
   end

   assign redirect = (sel != SEL_SEQ);

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: instruction-fetch stage. Owns the PC, feeds the combinational
// instruction memory and captures {instruction, PC+4, valid} into IF/ID.
// Redirects and flushes squash the wrong-path fetch with a single bubble.
// Optional: FETCH_ALINHAMENTO_CHECK_EN traps misaligned jr targets into a
// sticky error that freezes the PC and streams bubbles until reset.
module unidade_busca #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter logic [31:0] NOP      = unidade_busca_pkg::NOP
) (
   input logic            clock,
   input logic            reset_n,
   unidade_busca_if.slave bus
);

   import unidade_busca_pkg::ifid_t;
   import unidade_busca_pkg::PC_INCREMENTO;

   logic [31:0] pc_q;
   logic [31:0] pc_seq;
   logic [31:0] prox_pc;
   ifid_t       ifid_q;
   logic        redirect;
   logic        trava;
   logic        bolha;

   assign pc_seq = pc_q + PC_INCREMENTO;

   calc_prox_pc u_calc (
      .endereco_pc   (pc_q),
      .pc_mais4_ifid (ifid_q.pc_mais4),
      .branch_taken  (bus.branch_taken),
      .branch_offset (bus.branch_offset),
      .jump          (bus.jump),
      .jump_target   (bus.jump_target),
      .jr            (bus.jr),
      .jr_endereco   (bus.jr_endereco),
      .prox_pc       (prox_pc),
      .redirect      (redirect)
   );

`ifdef FETCH_ALINHAMENTO_CHECK_EN
   logic erro_q;
   logic jr_desalinhado;

   // jr has top priority, so a raised jr is always the redirect in effect
   assign jr_desalinhado = bus.jr && (bus.jr_endereco[1:0] != 2'b00);
   assign trava          = erro_q || jr_desalinhado;

   // Sticky alignment error, cleared only by reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                         erro_q <= 1'b0;
      else if (!bus.stall && jr_desalinhado) erro_q <= 1'b1;
   end

   assign bus.erro_alinhamento = erro_q;
`else
   assign trava                = 1'b0;
   assign bus.erro_alinhamento = 1'b0;
`endif

   assign bolha = redirect | bus.flush | trava;

   // PC and IF/ID update; stall freezes everything and drops redirect/flush
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q   <= PC_RESET;
         ifid_q <= '{instrucao: NOP, pc_mais4: 32'h0, valido: 1'b0};
      end else if (!bus.stall) begin
         if (!trava) pc_q <= prox_pc;
         if (bolha) ifid_q <= '{instrucao: NOP, pc_mais4: pc_seq, valido: 1'b0};
         else       ifid_q <= '{instrucao: bus.instrucao_in, pc_mais4: pc_seq, valido: 1'b1};
      end
   end

   assign bus.endereco_PC    = pc_q;
   assign bus.instrucao_ifid = ifid_q.instrucao;
   assign bus.pc_mais4_ifid  = ifid_q.pc_mais4;
   assign bus.valido_ifid    = ifid_q.valido;

endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed bench for the fetch stage. A behavioural model
// predicts each edge's outcome, pushes it to a scoreboard queue, and the entry
// is popped and compared after the edge. Directed constant checks pin the
// key addresses. Covers FETCH_ALINHAMENTO_CHECK_EN in either build.
module tb_unidade_busca;

   import unidade_busca_pkg::*;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] pm4;
      logic        v;
      logic        err;
   } estado_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   unidade_busca_if bus ();

   unidade_busca #(.PC_RESET(32'h0000_0000), .NOP(32'h0000_0000)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   // Combinational instruction memory: a distinct word per address
   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'h5EED_0000 + a;
   endfunction

   assign bus.instrucao_in = mem(bus.endereco_PC);

   estado_t m;
   estado_t fila[$];
   int      checks = 0;
   int      erros  = 0;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         erros++;
         $error("FAIL %s: obtido=%h esperado=%h", tag, obs, exp);
      end
   endtask

   task automatic confere(input string tag, input estado_t e);
      verifica({tag, ".pc"},  bus.endereco_PC, e.pc);
      verifica({tag, ".v"},   {31'b0, bus.valido_ifid}, {31'b0, e.v});
      verifica({tag, ".ins"}, bus.instrucao_ifid, e.ins);
      verifica({tag, ".err"}, {31'b0, bus.erro_alinhamento}, {31'b0, e.err});
      if (e.v) verifica({tag, ".pm4"}, bus.pc_mais4_ifid, e.pm4);
   endtask

   task automatic modelo_reset();
      m = '{pc: 32'h0, ins: NOP, pm4: 32'h0, v: 1'b0, err: 1'b0};
   endtask

   task automatic limpa();
      bus.stall = 0; bus.flush = 0; bus.branch_taken = 0; bus.branch_offset = 0;
      bus.jump = 0; bus.jump_target = 0; bus.jr = 0; bus.jr_endereco = 0;
   endtask

   // Predict one edge from the driven inputs, then clock and compare
   task automatic passo(input string tag);
      estado_t     e;
      estado_t     r;
      logic [31:0] alvo;
      e = m;
      if (!bus.stall) begin
         if (m.err) begin
            e.ins = NOP; e.v = 1'b0;
         end else if (bus.jr || bus.jump || bus.branch_taken) begin
            e.ins = NOP; e.v = 1'b0;
            if (bus.jr)        alvo = bus.jr_endereco & 32'hFFFF_FFFC;
            else if (bus.jump) alvo = {m.pm4[31:28], bus.jump_target, 2'b00};
            else               alvo = m.pm4 + (bus.branch_offset << 2);
`ifdef FETCH_ALINHAMENTO_CHECK_EN
            if (bus.jr && bus.jr_endereco[1:0] != 2'b00) e.err = 1'b1;
            else
`endif
            e.pc = alvo;
         end else if (bus.flush) begin
            e.ins = NOP; e.v = 1'b0; e.pc = m.pc + 32'd4;
         end else begin
            e.ins = mem(m.pc); e.pm4 = m.pc + 32'd4; e.v = 1'b1; e.pc = m.pc + 32'd4;
         end
      end
      fila.push_back(e);
      @(posedge clock);
      #1;
      r = fila.pop_front();
      m = r;
      confere(tag, r);
   endtask

   initial begin
      limpa();
      modelo_reset();

      // Reset asserted asynchronously between edges
      #2 reset_n = 1'b0;
      #1 confere("reset", m);
      @(posedge clock);
      #1 reset_n = 1'b1;

      // Free run from PC_RESET
      passo("run0");
      verifica("run0_ins", bus.instrucao_ifid, 32'h5EED_0000);
      verifica("run0_pm4", bus.pc_mais4_ifid, 32'h4);
      passo("run1");
      passo("run2");
      verifica("run2_pc", bus.endereco_PC, 32'hC);
      verifica("run2_pm4", bus.pc_mais4_ifid, 32'hC);
      passo("run3");

      // Branch back by two words from pc_mais4 = 0x10
      bus.branch_taken = 1; bus.branch_offset = 32'hFFFF_FFFE;
      passo("br");
      verifica("br_pc", bus.endereco_PC, 32'h8);
      verifica("br_v", {31'b0, bus.valido_ifid}, 32'h0);
      limpa();
      passo("br_tgt");
      verifica("br_tgt_ins", bus.instrucao_ifid, 32'h5EED_0008);
      verifica("br_tgt_pm4", bus.pc_mais4_ifid, 32'hC);

      // jr, jump and branch together: jr wins
      bus.jr = 1; bus.jr_endereco = 32'h40; bus.jump = 1; bus.jump_target = 26'h3F;
      bus.branch_taken = 1; bus.branch_offset = 32'd5;
      passo("prio");
      verifica("prio_pc", bus.endereco_PC, 32'h40);
      limpa();
      passo("prio_tgt");
      verifica("prio_tgt_v", {31'b0, bus.valido_ifid}, 32'h1);

      // Stall with a pending branch for three cycles
      bus.stall = 1; bus.branch_taken = 1; bus.branch_offset = 32'd1;
      for (int i = 0; i < 3; i++) begin
         passo("stall");
         verifica("stall_pc", bus.endereco_PC, 32'h44);
      end
      bus.stall = 0;
      passo("stall_br");
      verifica("stall_br_pc", bus.endereco_PC, 32'h48);
      limpa();
      passo("stall_tgt");

      // Jump to 0x1C, run to 0x20, then flush
      bus.jump = 1; bus.jump_target = 26'h7;
      passo("jmp");
      limpa();
      passo("jmp_tgt");
      verifica("jmp_tgt_pc", bus.endereco_PC, 32'h20);
      bus.flush = 1;
      passo("flush");
      verifica("flush_pc", bus.endereco_PC, 32'h24);
      limpa();
      passo("flush_next");
      verifica("flush_next_ins", bus.instrucao_ifid, 32'h5EED_0024);

      // Jump keeps the upper nibble of pc_mais4
      bus.jr = 1; bus.jr_endereco = 32'hF000_0000;
      passo("jr_hi");
      limpa();
      passo("jr_hi_tgt");
      bus.jump = 1; bus.jump_target = 26'h5;
      passo("jmp_hi");
      verifica("jmp_hi_pc", bus.endereco_PC, 32'hF000_0014);
      limpa();
      passo("jmp_hi_tgt");

      // Sequential wrap at 2^32
      bus.jr = 1; bus.jr_endereco = 32'hFFFF_FFFC;
      passo("wrap_jr");
      limpa();
      passo("wrap");
      verifica("wrap_pc", bus.endereco_PC, 32'h0);

      // Reset mid-stall with a pending branch: nothing is retained
      bus.stall = 1; bus.branch_taken = 1; bus.branch_offset = 32'd3;
      passo("pre_rst");
      #2 reset_n = 1'b0;
      modelo_reset();
      #1 confere("rst_mid", m);
      @(posedge clock);
      #1 reset_n = 1'b1;
      limpa();
      passo("post_rst");
      verifica("post_rst_pc", bus.endereco_PC, 32'h4);

`ifdef FETCH_ALINHAMENTO_CHECK_EN
      // Misaligned jr traps and freezes the PC
      bus.jr = 1; bus.jr_endereco = 32'h42;
      passo("mis");
      verifica("mis_pc", bus.endereco_PC, 32'h4);
      limpa();
      passo("mis_hold0");
      passo("mis_hold1");
      bus.stall = 1;
      passo("mis_stall");
      bus.stall = 0;
      #2 reset_n = 1'b0;
      modelo_reset();
      #1 confere("mis_rst", m);
      @(posedge clock);
      #1 reset_n = 1'b1;
      passo("mis_run");
`else
      // Misaligned jr target is word-aligned
      bus.jr = 1; bus.jr_endereco = 32'h42;
      passo("mis");
      verifica("mis_pc", bus.endereco_PC, 32'h40);
      limpa();
      passo("mis_run");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, erros);
      $finish;
   end

endmodule
